pi_digit_emitter: RTL and testbench

//  Consumer of the flat multiprecision result bus produced by the pi calculator. Converts the

---
 rtl/pi_pkg.sv | 26 ++
 rtl/pi_mul10_limb.sv | 27 ++
 rtl/pi_digit_emitter.sv | 155 +++++++++++++++
 tb/tb_pi_digit_emitter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pi_pkg
//  Description : Shared defaults, radix and state encoding for the pi digit
//                emitter and its limb multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package pi_pkg;

    // Default geometry of the multiprecision result bus
    localparam int DEF_L    = 10;
    localparam int DEF_N    = 10;
    localparam int DEF_NDIG = 8;

    // Output number base
    localparam int RADIX    = 10;

    // Emitter state encoding
    localparam logic [3:0] IDLE     = 4'h0;
    localparam logic [3:0] EMIT_INT = 4'h1;
    localparam logic [3:0] MUL      = 4'h2;
    localparam logic [3:0] EMIT     = 4'h3;
    localparam logic [3:0] DONE     = 4'h4;

endpackage
`default_nettype wire

// File: rtl/pi_mul10_limb.sv
`default_nettype none
// ============================================================================
//  Module      : pi_mul10_limb
//  Description : Combinational limb * 10 + carry-in. Returns the low N bits
//                and a 4-bit carry-out (never above 9 since carry-in <= 9).
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_mul10_limb
    import pi_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] i_limb,
    input  logic [3:0]   i_carry,
    output logic [N-1:0] o_low,
    output logic [3:0]   o_carry
);

    logic [N+3:0] w_prod;

    // Widen before multiplying so the decimal carry lands in the top nibble
    assign w_prod  = ({4'b0000, i_limb} * (N+4)'(RADIX)) + {{N{1'b0}}, i_carry};
    assign o_low   = w_prod[N-1:0];
    assign o_carry = w_prod[N+3:N];

endmodule
`default_nettype wire

// File: rtl/pi_digit_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : pi_digit_emitter
//  Description : Converts a binary fixed-point value (integer limb on top,
//                fraction limbs below) into a stream of decimal digits over a
//                valid/ready handshake. Each fraction digit is the carry out
//                of one in-place multiply-by-10 sweep of the fraction limbs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_digit_emitter
    import pi_pkg::*;
#(
    parameter int L    = DEF_L,
    parameter int N    = DEF_N,
    parameter int NDIG = DEF_NDIG
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [L*N-1:0] sum_in,
    input  logic           start,
    output logic           busy,
    output logic [3:0]     digit,
    output logic           digit_valid,
    input  logic           digit_ready,
    output logic           int_ovf,
    output logic           done
);

    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
    localparam int CNT_W = (NDIG > 0) ? $clog2(NDIG + 1) : 1;

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic [N-1:0]     r_frac [L];
    logic [3:0]       r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_dig_cnt;
    logic [3:0]       r_digit;
    logic             r_int_ovf;

    logic             w_hs;
    logic             w_last_mul;
    logic             w_last_digit;
    logic [N-1:0]     w_limb_sel;
    logic [N-1:0]     w_low;
    logic [3:0]       w_cout;
    logic [N-1:0]     w_int_limb;

    assign w_int_limb   = sum_in[N*(L-1) +: N];
    assign w_hs         = digit_valid && digit_ready;
    assign w_last_mul   = (int'(r_idx) == L - 2);
    assign w_last_digit = (int'(r_dig_cnt) + 1 == NDIG);
    assign w_limb_sel   = r_frac[r_idx];

    // Single shared multiplier, fed by the limb currently addressed by r_idx
    pi_mul10_limb #(
        .N       (N)
    ) u_mul10 (
        .i_limb  (w_limb_sel),
        .i_carry (r_carry),
        .o_low   (w_low),
        .o_carry (w_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; with a single limb there is no sweep, so fraction
    // digits go straight back to EMIT carrying a zero digit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = EMIT_INT;
            end
            EMIT_INT: begin
                if (w_hs) w_state_nxt = (L > 1) ? MUL : EMIT;
            end
            MUL: begin
                if (w_last_mul) w_state_nxt = EMIT;
            end
            EMIT: begin
                if (w_hs) begin
                    if (w_last_digit) w_state_nxt = DONE;
                    else              w_state_nxt = (L > 1) ? MUL : EMIT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot, in-place x10 sweep, digit/counter bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) r_frac[k] <= '0;
            r_carry   <= '0;
            r_idx     <= '0;
            r_dig_cnt <= '0;
            r_digit   <= '0;
            r_int_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < L; k++) r_frac[k] <= sum_in[N*k +: N];
                        r_digit   <= w_int_limb[3:0];
                        r_int_ovf <= (w_int_limb > N'(9));
                    end
                end
                EMIT_INT: begin
                    if (w_hs) begin
                        r_idx     <= '0;
                        r_carry   <= '0;
                        r_dig_cnt <= '0;
                        if (L == 1) r_digit <= '0;
                    end
                end
                MUL: begin
                    r_frac[r_idx] <= w_low;
                    r_carry       <= w_cout;
                    r_idx         <= r_idx + 1'b1;
                    if (w_last_mul) r_digit <= w_cout;
                end
                EMIT: begin
                    if (w_hs) begin
                        r_dig_cnt <= r_dig_cnt + 1'b1;
                        r_idx     <= '0;
                        r_carry   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign digit_valid = (r_state == EMIT_INT) || (r_state == EMIT);
    assign busy        = (r_state == EMIT_INT) || (r_state == MUL) || (r_state == EMIT);
    assign done        = (r_state == DONE);
    assign digit       = r_digit;
    assign int_ovf     = r_int_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pi_digit_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_digit_emitter
//  Description : Scoreboard bench for pi_digit_emitter (L=4, N=10, NDIG=4).
//                Expected digits come from a 30-bit fraction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_digit_emitter;

    localparam int L    = 4;
    localparam int N    = 10;
    localparam int NDIG = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [L*N-1:0] sum_in;
    logic           start;
    logic           busy;
    logic [3:0]     digit;
    logic           digit_valid;
    logic           digit_ready;
    logic           int_ovf;
    logic           done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    pi_digit_emitter #(
        .L           (L),
        .N           (N),
        .NDIG        (NDIG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sum_in      (sum_in),
        .start       (start),
        .busy        (busy),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .int_ovf     (int_ovf),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    // Load the bus, push expected digits, pulse start for one cycle
    task automatic load_and_start(input logic [N-1:0] l3, input logic [N-1:0] l2,
                                  input logic [N-1:0] l1, input logic [N-1:0] l0);
        longint f;
        sum_in = {l3, l2, l1, l0};
        exp_q.push_back(int'(l3[3:0]));
        f = longint'({l2, l1, l0});
        for (int d = 0; d < NDIG; d++) begin
            f = f * 10;
            exp_q.push_back(int'(f >> 30));
            f = f & ((longint'(1) << 30) - 1);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Consume the digit stream against the scoreboard
    task automatic drain(input bit exp_ovf, input int bp_idx, input bit pulse_start);
        int         since_acc = 0;
        int         acc = 0;
        int         exp_d;
        bit         have_acc = 0;
        bit         last_v = 0;
        bit         finished = 0;
        logic [3:0] held;
        digit_ready = 1'b1;
        n_tests++;
        if (digit_valid !== 1'b1) begin
            n_fail++; $display("FAIL int_latency: valid=%b required 1", digit_valid);
        end
        n_tests++;
        if (int_ovf !== exp_ovf) begin
            n_fail++; $display("FAIL int_ovf_start: got %b required %b", int_ovf, exp_ovf);
        end
        for (int it = 0; it < 300 && !finished; it++) begin
            since_acc++;
            if (done === 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL early_done: done=1 with %0d digits pending", exp_q.size());
            end
            if (digit_valid && !last_v && have_acc) begin
                n_tests++;
                if (since_acc != L) begin
                    n_fail++; $display("FAIL digit_gap: got %0d cycles required %0d", since_acc, L);
                end
            end
            if (digit_valid && !last_v && acc == bp_idx) begin
                digit_ready = 1'b0;
                held = digit;
                repeat (20) begin
                    cyc();
                    n_tests++;
                    if (digit_valid !== 1'b1 || digit !== held) begin
                        n_fail++;
                        $display("FAIL backpressure_hold: valid=%b digit=%0d required 1/%0d",
                                 digit_valid, digit, held);
                    end
                end
                digit_ready = 1'b1;
            end
            if (pulse_start && acc == 1 && since_acc == 2) begin
                start  = 1'b1;
                sum_in = '1;
            end else begin
                start = 1'b0;
            end
            if (digit_valid && digit_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL extra_digit: got %0d required none", digit);
                end else begin
                    exp_d = exp_q.pop_front();
                    n_tests++;
                    if (digit !== 4'(exp_d)) begin
                        n_fail++; $display("FAIL digit[%0d]: got %0d required %0d", acc, digit, exp_d);
                    end
                end
                acc++;
                have_acc  = 1;
                since_acc = 0;
                if (exp_q.size() == 0) finished = 1;
            end
            last_v = digit_valid;
            cyc();
        end
        start = 1'b0;
        if (!finished) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: got %0d digits required %0d", acc, NDIG + 1);
            exp_q.delete();
        end else begin
            n_tests++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL done_pulse: done=%b busy=%b required 1/0", done, busy);
            end
            start = 1'b1;
            cyc();
            start = 1'b0;
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0 || digit_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL after_done: done=%b busy=%b valid=%b required 0/0/0",
                         done, busy, digit_valid);
            end
            n_tests++;
            if (int_ovf !== exp_ovf) begin
                n_fail++; $display("FAIL int_ovf_sticky: got %b required %b", int_ovf, exp_ovf);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; digit_ready = 1'b0; sum_in = '0;
        repeat (3) cyc();
        n_tests++;
        if (busy !== 1'b0 || digit_valid !== 1'b0 || done !== 1'b0 ||
            int_ovf !== 1'b0 || digit !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b done=%b ovf=%b digit=%0d required all 0",
                     busy, digit_valid, done, int_ovf, digit);
        end
        rst = 1'b0;
        repeat (2) cyc();
        n_tests++;
        if (digit_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: valid=%b busy=%b required 0/0", digit_valid, busy);
        end
    endtask

    task automatic test_half();
        digit_ready = 1'b1;
        load_and_start(10'd3, 10'd512, 10'd0, 10'd0);
        drain(1'b0, -1, 1'b0);
    endtask

    task automatic test_quarter_timing();
        load_and_start(10'd3, 10'd256, 10'd0, 10'd0);
        drain(1'b0, -1, 1'b0);
    endtask

    task automatic test_carry_chain();
        load_and_start(10'd0, 10'd145, 10'd0, 10'd0);
        drain(1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        load_and_start(10'd0, 10'd145, 10'd0, 10'd0);
        drain(1'b0, 2, 1'b0);
    endtask

    task automatic test_reset_abort();
        int hs = 0;
        digit_ready = 1'b1;
        load_and_start(10'd3, 10'd256, 10'd0, 10'd0);
        for (int it = 0; it < 100 && hs < 2; it++) begin
            if (digit_valid && digit_ready) hs++;
            cyc();
        end
        cyc();
        rst = 1'b1;
        cyc();
        n_tests++;
        if (busy !== 1'b0 || digit_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b valid=%b done=%b required 0/0/0", busy, digit_valid, done);
        end
        rst = 1'b0;
        exp_q.delete();
        cyc();
        n_tests++;
        if (digit_valid !== 1'b0) begin
            n_fail++; $display("FAIL no_digit_after_reset: valid=%b required 0", digit_valid);
        end
        load_and_start(10'd3, 10'd256, 10'd0, 10'd0);
        drain(1'b0, -1, 1'b1);
    endtask

    task automatic test_int_ovf();
        load_and_start(10'd12, 10'd0, 10'd0, 10'd0);
        drain(1'b1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_and_start(10'd3, 10'd512, 10'd0, 10'd0);
        drain(1'b0, -1, 1'b0);
        load_and_start(10'd9, 10'd1023, 10'd1023, 10'd1023);
        drain(1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_half();
        test_quarter_timing();
        test_carry_chain();
        test_backpressure();
        test_reset_abort();
        test_int_ovf();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
